exu_div: RTL and testbench

EXU_DIV -- requirements
Module: exu_div

---
 rtl/exu_div_pkg.sv | 21 ++
 rtl/exu_div.sv | 164 ++++++++++++++++
 tb/tb_exu_div.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/exu_div_pkg.sv
// ============================================================================
// Module : exu_div_pkg
// Brief  : Shared widths and FSM state encoding for the iterative divider.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package exu_div_pkg;

    localparam int XLEN_DEF                = 32;
    localparam int REG_FILE_ADDR_WIDTH_DEF = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

`default_nettype wire

// File: rtl/exu_div.sv
// ============================================================================
// Module : exu_div
// Brief  : Multi-cycle restoring divider for DIV/DIVU/REM/REMU with
//          registered single-cycle writeback strobe.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module exu_div
    import exu_div_pkg::*;
#(
    parameter int XLEN                = XLEN_DEF,
    parameter int REG_FILE_ADDR_WIDTH = REG_FILE_ADDR_WIDTH_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           issue_valid,
    input  logic [XLEN-1:0]                issue_rs1_data,
    input  logic [XLEN-1:0]                issue_rs2_data,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] issue_rd_addr,
    input  logic                           issue_unsign,
    input  logic                           issue_rem,
    input  logic                           pipe_flush,
    output logic                           div_busy,
    output logic                           wb_valid,
    output logic                           wb_rd_wr_en,
    output logic [REG_FILE_ADDR_WIDTH-1:0] wb_rd_addr,
    output logic [XLEN-1:0]                wb_data
);

    localparam int               CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] c_last   = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  c_minint = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t r_state;
    div_state_t w_state_nxt;

    logic [XLEN-1:0]                r_quot;
    logic [XLEN-1:0]                r_rem;
    logic [XLEN-1:0]                r_dsor;
    logic [CNT_W-1:0]               r_cnt;
    logic [REG_FILE_ADDR_WIDTH-1:0] r_rd_addr;
    logic                           r_rem_sel;
    logic                           r_neg_q;
    logic                           r_neg_r;
    logic [XLEN-1:0]                r_wb_data;
    logic [REG_FILE_ADDR_WIDTH-1:0] r_wb_rd_addr;

    // Issue-side decode: operand magnitudes and the two short-circuit cases
    logic            w_accept;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_div_zero;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_spec_data;

    assign w_accept    = (r_state == IDLE) && issue_valid && !pipe_flush;
    assign w_a_neg     = !issue_unsign && issue_rs1_data[XLEN-1];
    assign w_b_neg     = !issue_unsign && issue_rs2_data[XLEN-1];
    assign w_a_mag     = w_a_neg ? (~issue_rs1_data + 1'b1) : issue_rs1_data;
    assign w_b_mag     = w_b_neg ? (~issue_rs2_data + 1'b1) : issue_rs2_data;
    assign w_div_zero  = (issue_rs2_data == '0);
    assign w_ovf       = !issue_unsign && (issue_rs1_data == c_minint) && (issue_rs2_data == '1);
    assign w_special   = w_div_zero || w_ovf;
    assign w_spec_data = w_div_zero ? (issue_rem ? issue_rs1_data : '1)
                                    : (issue_rem ? '0 : c_minint);

    // One restoring step: shift next dividend bit into the partial remainder
    logic [XLEN:0]   w_rem_sh;
    logic [XLEN:0]   w_diff;
    logic            w_ge;
    logic [XLEN-1:0] w_rem_nxt;
    logic [XLEN-1:0] w_quot_nxt;
    logic [XLEN-1:0] w_q_res;
    logic [XLEN-1:0] w_r_res;
    logic [XLEN-1:0] w_result;

    assign w_rem_sh   = {r_rem, r_quot[XLEN-1]};
    assign w_diff     = w_rem_sh - {1'b0, r_dsor};
    assign w_ge       = !w_diff[XLEN];
    assign w_rem_nxt  = w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
    assign w_quot_nxt = {r_quot[XLEN-2:0], w_ge};
    assign w_q_res    = r_neg_q ? (~w_quot_nxt + 1'b1) : w_quot_nxt;
    assign w_r_res    = r_neg_r ? (~w_rem_nxt + 1'b1) : w_rem_nxt;
    assign w_result   = r_rem_sel ? w_r_res : w_q_res;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_special ? DONE : RUN;
                end
            end
            RUN: begin
                if (r_cnt == c_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        div_busy = (r_state != IDLE);
        wb_valid = (r_state == DONE);
    end

    // Result registers only move on entry to DONE, so they hold between strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_quot       <= '0;
            r_rem        <= '0;
            r_dsor       <= '0;
            r_cnt        <= '0;
            r_rd_addr    <= '0;
            r_rem_sel    <= 1'b0;
            r_neg_q      <= 1'b0;
            r_neg_r      <= 1'b0;
            r_wb_data    <= '0;
            r_wb_rd_addr <= '0;
        end else if (w_accept) begin
            r_quot    <= w_a_mag;
            r_rem     <= '0;
            r_dsor    <= w_b_mag;
            r_cnt     <= '0;
            r_rd_addr <= issue_rd_addr;
            r_rem_sel <= issue_rem;
            r_neg_q   <= w_a_neg ^ w_b_neg;
            r_neg_r   <= w_a_neg;
            if (w_special) begin
                r_wb_data    <= w_spec_data;
                r_wb_rd_addr <= issue_rd_addr;
            end
        end else if (r_state == RUN) begin
            r_quot <= w_quot_nxt;
            r_rem  <= w_rem_nxt;
            r_cnt  <= r_cnt + 1'b1;
            if (r_cnt == c_last) begin
                r_wb_data    <= w_result;
                r_wb_rd_addr <= r_rd_addr;
            end
        end
    end

    assign wb_data     = r_wb_data;
    assign wb_rd_addr  = r_wb_rd_addr;
    assign wb_rd_wr_en = wb_valid && (r_wb_rd_addr != '0);

endmodule

`default_nettype wire

// File: tb/tb_exu_div.sv
// ============================================================================
// Module : tb_exu_div
// Brief  : Directed self-checking bench for exu_div with hand-computed results.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_exu_div;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [31:0] issue_rs1_data;
    logic [31:0] issue_rs2_data;
    logic [4:0]  issue_rd_addr;
    logic        issue_unsign;
    logic        issue_rem;
    logic        pipe_flush;
    logic        div_busy;
    logic        wb_valid;
    logic        wb_rd_wr_en;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_data;

    int n_tests = 0;
    int n_fail  = 0;

    exu_div #(.XLEN(32), .REG_FILE_ADDR_WIDTH(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .issue_valid    (issue_valid),
        .issue_rs1_data (issue_rs1_data),
        .issue_rs2_data (issue_rs2_data),
        .issue_rd_addr  (issue_rd_addr),
        .issue_unsign   (issue_unsign),
        .issue_rem      (issue_rem),
        .pipe_flush     (pipe_flush),
        .div_busy       (div_busy),
        .wb_valid       (wb_valid),
        .wb_rd_wr_en    (wb_rd_wr_en),
        .wb_rd_addr     (wb_rd_addr),
        .wb_data        (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // The bench never issues while the unit is busy
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(issue_valid && div_busy)) else begin
                n_fail++;
                $error("FAIL issue_while_busy: observed 1 expected 0");
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        input logic uns, input logic rem, input logic flush);
        @(negedge clk);
        issue_valid    = 1'b1;
        issue_rs1_data = a;
        issue_rs2_data = b;
        issue_rd_addr  = rd;
        issue_unsign   = uns;
        issue_rem      = rem;
        pipe_flush     = flush;
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
        pipe_flush  = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic uns, input logic rem,
                         input int exp_lat, input logic [31:0] exp_data);
        int          wb_cyc   = 0;
        int          wb_cnt   = 0;
        int          busy_bad = 0;
        logic [31:0] got      = '0;
        logic [4:0]  got_rd   = '0;
        logic        got_we   = 1'b0;
        send(a, b, rd, uns, rem, 1'b0);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (wb_valid) begin
                wb_cnt++;
                wb_cyc = k;
                got    = wb_data;
                got_rd = wb_rd_addr;
                got_we = wb_rd_wr_en;
            end
            if (div_busy !== (k <= exp_lat)) busy_bad++;
        end
        chk({tag, "_lat"},   wb_cyc,   exp_lat);
        chk({tag, "_count"}, wb_cnt,   1);
        chk({tag, "_data"},  got,      exp_data);
        chk({tag, "_rd"},    32'(got_rd), 32'(rd));
        chk({tag, "_we"},    32'(got_we), 32'(rd != 5'd0));
        chk({tag, "_busy"},  busy_bad, 0);
    endtask

    initial begin
        int wb_seen;
        int busy_seen;
        rst            = 1'b1;
        issue_valid    = 1'b0;
        issue_rs1_data = '0;
        issue_rs2_data = '0;
        issue_rd_addr  = '0;
        issue_unsign   = 1'b0;
        issue_rem      = 1'b0;
        pipe_flush     = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy",  32'(div_busy),    0);
        chk("rst_wbv",   32'(wb_valid),    0);
        chk("rst_we",    32'(wb_rd_wr_en), 0);
        chk("rst_data",  wb_data,          0);
        chk("rst_rd",    32'(wb_rd_addr),  0);
        rst = 1'b0;
        @(negedge clk);

        do_op("div_100_7",   32'd100,        32'd7,          5'd3,  1'b0, 1'b0, 33, 32'd14);
        do_op("rem_m100_7",  32'hFFFF_FF9C,  32'd7,          5'd4,  1'b0, 1'b1, 33, 32'hFFFF_FFFE);
        do_op("divu_max_2",  32'hFFFF_FFFF,  32'd2,          5'd5,  1'b1, 1'b0, 33, 32'h7FFF_FFFF);
        do_op("remu_max_2",  32'hFFFF_FFFF,  32'd2,          5'd6,  1'b1, 1'b1, 33, 32'd1);
        do_op("div_m7_2",    32'hFFFF_FFF9,  32'd2,          5'd7,  1'b0, 1'b0, 33, 32'hFFFF_FFFD);
        do_op("rem_7_m2",    32'd7,          32'hFFFF_FFFE,  5'd8,  1'b0, 1'b1, 33, 32'd1);
        do_op("div_5_0",     32'd5,          32'd0,          5'd9,  1'b0, 1'b0, 1,  32'hFFFF_FFFF);
        do_op("rem_5_0",     32'd5,          32'd0,          5'd10, 1'b0, 1'b1, 1,  32'd5);
        do_op("div_ovf",     32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 1'b0, 1'b0, 1,  32'h8000_0000);
        do_op("rem_ovf",     32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 1'b0, 1'b1, 1,  32'd0);
        do_op("divu_min_m1", 32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 1'b1, 1'b0, 33, 32'd0);
        do_op("remu_min_m1", 32'h8000_0000,  32'hFFFF_FFFF,  5'd14, 1'b1, 1'b1, 33, 32'h8000_0000);
        do_op("div_rd0",     32'd100,        32'd7,          5'd0,  1'b0, 1'b0, 33, 32'd14);

        // Flushed issue: nothing happens and the last result stays on wb_data
        send(32'd50, 32'd5, 5'd15, 1'b0, 1'b0, 1'b1);
        wb_seen   = 0;
        busy_seen = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (wb_valid) wb_seen++;
            if (div_busy) busy_seen++;
        end
        chk("flush_busy", busy_seen, 0);
        chk("flush_wb",   wb_seen,   0);
        chk("hold_data",  wb_data,   32'd14);
        chk("hold_rd",    32'(wb_rd_addr), 0);

        // Reset in the middle of a division
        send(32'd1000, 32'd3, 5'd17, 1'b0, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        chk("mid_busy_pre", 32'(div_busy), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(div_busy), 0);
        chk("mid_rst_wbv",  32'(wb_valid), 0);
        chk("mid_rst_data", wb_data,       0);
        @(negedge clk);
        rst     = 1'b0;
        wb_seen = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (wb_valid) wb_seen++;
        end
        chk("mid_rst_nowb", wb_seen, 0);
        do_op("post_rst_div", 32'd1000, 32'd3, 5'd17, 1'b0, 1'b0, 33, 32'd333);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
